// File: rtl/rob_commit_buffer_if.sv
// rob_commit_buffer_if: dispatch, writeback, operand lookup and commit signals of the reorder buffer.
interface rob_commit_buffer_if #(parameter int ROB_IDX_WIDTH = 5);
   logic                     disp_valid;
   logic [4:0]               disp_rd_addr;
   logic [31:0]              disp_pc;
   logic                     disp_ready;
   logic [ROB_IDX_WIDTH-1:0] disp_rob_idx;
   logic                     wb_valid;
   logic [ROB_IDX_WIDTH-1:0] wb_rob_idx;
   logic [31:0]              wb_data;
   logic                     wb_mispredict;
   logic [31:0]              wb_target;
   logic [ROB_IDX_WIDTH-1:0] rs1_rob_idx;
   logic [ROB_IDX_WIDTH-1:0] rs2_rob_idx;
   logic                     rs1_done;
   logic                     rs2_done;
   logic [31:0]              rs1_data;
   logic [31:0]              rs2_data;
   logic                     commit_valid;
   logic                     regf_we;
   logic [4:0]               commit_rd_addr;
   logic [31:0]              commit_data;
   logic [ROB_IDX_WIDTH-1:0] commit_rob_idx;
   logic [31:0]              commit_pc;
   logic                     flush;
   logic [31:0]              flush_pc;
   modport master (
      output disp_valid, disp_rd_addr, disp_pc, wb_valid, wb_rob_idx, wb_data, wb_mispredict,
             wb_target, rs1_rob_idx, rs2_rob_idx,
      input  disp_ready, disp_rob_idx, rs1_done, rs2_done, rs1_data, rs2_data, commit_valid,
             regf_we, commit_rd_addr, commit_data, commit_rob_idx, commit_pc, flush, flush_pc
   );
   modport slave (
      input  disp_valid, disp_rd_addr, disp_pc, wb_valid, wb_rob_idx, wb_data, wb_mispredict,
             wb_target, rs1_rob_idx, rs2_rob_idx,
      output disp_ready, disp_rob_idx, rs1_done, rs2_done, rs1_data, rs2_data, commit_valid,
             regf_we, commit_rd_addr, commit_data, commit_rob_idx, commit_pc, flush, flush_pc
   );
endinterface

// File: rtl/rob_commit_buffer.sv
// rob_commit_buffer: circular reorder buffer retiring results in program order, flushing on mispredict.
// Optional retired-instruction counter output instret enabled by macro ROB_INSTRET_EN.
module rob_commit_buffer #(
   parameter int ROB_DEPTH     = 32,
   parameter int ROB_IDX_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   rob_commit_buffer_if.slave  rob
`ifdef ROB_INSTRET_EN
   ,
   output logic [63:0]         instret
`endif
);
   localparam int W = ROB_IDX_WIDTH;
   logic [W:0]   head_q, tail_q;
   logic         valid_q [ROB_DEPTH];
   logic         done_q  [ROB_DEPTH];
   logic         misp_q  [ROB_DEPTH];
   logic [4:0]   rd_q    [ROB_DEPTH];
   logic [31:0]  data_q  [ROB_DEPTH];
   logic [31:0]  pc_q    [ROB_DEPTH];
   logic [31:0]  tgt_q   [ROB_DEPTH];
   logic [W-1:0] hi, ti;
   logic         full, disp_fire;
   assign hi = head_q[W-1:0];
   assign ti = tail_q[W-1:0];
   // The wrap bit separates full from empty when the index bits coincide.
   assign full           = (hi == ti) && (head_q[W] != tail_q[W]);
   assign disp_fire      = rob.disp_valid && !full;
   assign rob.disp_ready = !full;
   assign rob.disp_rob_idx = ti;
   assign rob.rs1_done   = valid_q[rob.rs1_rob_idx] && done_q[rob.rs1_rob_idx];
   assign rob.rs2_done   = valid_q[rob.rs2_rob_idx] && done_q[rob.rs2_rob_idx];
   assign rob.rs1_data   = data_q[rob.rs1_rob_idx];
   assign rob.rs2_data   = data_q[rob.rs2_rob_idx];
   assign rob.commit_valid   = valid_q[hi] && done_q[hi];
   assign rob.regf_we        = rob.commit_valid && (rd_q[hi] != 5'd0);
   assign rob.commit_rd_addr = rd_q[hi];
   assign rob.commit_data    = data_q[hi];
   assign rob.commit_rob_idx = hi;
   assign rob.commit_pc      = pc_q[hi];
   assign rob.flush          = rob.commit_valid && misp_q[hi];
   assign rob.flush_pc       = tgt_q[hi];
   always_ff @(posedge clk) begin
      if (rst || rob.flush) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
            misp_q[i]  <= 1'b0;
            if (rst) begin
               rd_q[i]   <= '0;
               data_q[i] <= '0;
               pc_q[i]   <= '0;
               tgt_q[i]  <= '0;
            end
         end
      end else begin
         if (disp_fire) begin
            valid_q[ti] <= 1'b1;
            done_q[ti]  <= 1'b0;
            misp_q[ti]  <= 1'b0;
            rd_q[ti]    <= rob.disp_rd_addr;
            pc_q[ti]    <= rob.disp_pc;
            tail_q      <= tail_q + 1'b1;
         end
         if (rob.wb_valid && valid_q[rob.wb_rob_idx]) begin
            done_q[rob.wb_rob_idx] <= 1'b1;
            data_q[rob.wb_rob_idx] <= rob.wb_data;
            misp_q[rob.wb_rob_idx] <= rob.wb_mispredict;
            tgt_q[rob.wb_rob_idx]  <= rob.wb_target;
         end
         // Retirement clears the head last so it wins over a repeated writeback to it.
         if (rob.commit_valid) begin
            valid_q[hi] <= 1'b0;
            done_q[hi]  <= 1'b0;
            misp_q[hi]  <= 1'b0;
            head_q      <= head_q + 1'b1;
         end
      end
   end
`ifdef ROB_INSTRET_EN
   logic [63:0] instret_q;
   always_ff @(posedge clk) instret_q <= rst ? 64'd0 : instret_q + {63'd0, rob.commit_valid};
   assign instret = instret_q;
`endif
endmodule
